// File: rtl/set_ctrl_pkg.sv
// rtl/set_ctrl_pkg.sv - shared types and constants for the time-setting sequencer
package set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_REPEAT_DELAY = 20;
  localparam int DEF_REPEAT_RATE  = 5;
  localparam int DEF_TIMEOUT_CYC  = 100;
  localparam int DEF_CNT_W        = 16;

  localparam logic FIELD_HR  = 1'b1;
  localparam logic FIELD_MIN = 1'b0;

  function automatic logic led_on(input logic set_mode, input logic sel_hr, input logic field);
    return set_mode && (sel_hr == field);
  endfunction

endpackage

// File: rtl/set_ctrl_if.sv
// rtl/set_ctrl_if.sv - key inputs and setting-counter strobes of the sequencer
interface set_ctrl_if;

  logic key_mode;
  logic key_sel;
  logic key_inc;
  logic set_mode;
  logic sel_hr;
  logic load_o;
  logic inc_hr;
  logic inc_min;
  logic commit_o;
  logic abort_o;
  logic LED_hr;
  logic LED_min;

  modport master (
    input  key_mode, key_sel, key_inc,
    output set_mode, sel_hr, load_o, inc_hr, inc_min, commit_o, abort_o, LED_hr, LED_min
  );

  modport slave (
    output key_mode, key_sel, key_inc,
    input  set_mode, sel_hr, load_o, inc_hr, inc_min, commit_o, abort_o, LED_hr, LED_min
  );

endinterface

// File: rtl/set_ctrl_key_debounce.sv
// rtl/set_ctrl_key_debounce.sv - key synchronizer, debouncer and press-edge detector
module key_debounce #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // Synchronizer resets high so a key held through reset looks already pressed;
  // armed only rises once the key has been seen released, so no stale press appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b0;
      press <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (!level && !sync2) begin
        armed <= 1'b1;
      end
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          level <= sync2;
          press <= sync2 & armed;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/set_ctrl.sv
// rtl/set_ctrl.sv - RUN/SET_HR/SET_MIN sequencer with auto-repeat and inactivity timeout
module set_ctrl
  import set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic        clk,
  input logic        rst_n,
  set_ctrl_if.master bus
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || TIMEOUT_CYC < 1 ||
      longint'(DEBOUNCE_CYC) > CNT_MAX || longint'(REPEAT_DELAY) > CNT_MAX ||
      longint'(REPEAT_RATE) > CNT_MAX || longint'(TIMEOUT_CYC) > CNT_MAX) begin : g_cnt_w_check
    $error("set_ctrl: CNT_W too narrow or cycle parameter below 1");
  end

  logic lvl_mode, lvl_sel, lvl_inc;
  logic prs_mode, prs_sel, prs_inc;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_key_mode (
    .clk(clk), .rst_n(rst_n), .raw(bus.key_mode), .level(lvl_mode), .press(prs_mode));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_key_sel (
    .clk(clk), .rst_n(rst_n), .raw(bus.key_sel), .level(lvl_sel), .press(prs_sel));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_key_inc (
    .clk(clk), .rst_n(rst_n), .raw(bus.key_inc), .level(lvl_inc), .press(prs_inc));

  state_t           state, state_nx;
  logic             sel_q, sel_nx;
  logic             load_q, inc_hr_q, inc_min_q, commit_q, abort_q;
  logic             load_nx, inc_hr_nx, inc_min_nx, commit_nx, abort_nx;
  logic             rep_active, rep_first;
  logic [CNT_W-1:0] rep_cnt, rep_limit, to_cnt;
  logic             rep_due, rep_start, rep_fire, to_due, activity;

  // Only one winner per cycle: mode > sel > inc press > repeat > timeout.
  always_comb begin
    state_nx   = state;
    sel_nx     = sel_q;
    load_nx    = 1'b0;
    inc_hr_nx  = 1'b0;
    inc_min_nx = 1'b0;
    commit_nx  = 1'b0;
    abort_nx   = 1'b0;
    rep_start  = 1'b0;
    rep_fire   = 1'b0;
    activity   = 1'b0;
    rep_limit  = rep_first ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1);
    rep_due    = rep_active && lvl_inc && (rep_cnt == rep_limit);
    to_due     = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
    unique case (state)
      RUN: begin
        if (prs_mode) begin
          state_nx = SET_HR;
          sel_nx   = FIELD_HR;
          load_nx  = 1'b1;
        end
      end
      SET_HR, SET_MIN: begin
        if (prs_mode) begin
          state_nx  = RUN;
          commit_nx = 1'b1;
        end else if (prs_sel) begin
          state_nx = (state == SET_HR) ? SET_MIN : SET_HR;
          sel_nx   = (state == SET_HR) ? FIELD_MIN : FIELD_HR;
          activity = 1'b1;
        end else if (prs_inc || rep_due) begin
          inc_hr_nx  = (state == SET_HR);
          inc_min_nx = (state == SET_MIN);
          rep_start  = prs_inc;
          rep_fire   = !prs_inc;
          activity   = 1'b1;
        end else if (to_due) begin
          state_nx = RUN;
          abort_nx = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      sel_q     <= FIELD_HR;
      load_q    <= 1'b0;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      commit_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      sel_q     <= sel_nx;
      load_q    <= load_nx;
      inc_hr_q  <= inc_hr_nx;
      inc_min_q <= inc_min_nx;
      commit_q  <= commit_nx;
      abort_q   <= abort_nx;
    end
  end

  // Repeat stops on release or any state change; timeout only runs inside SET states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_active <= 1'b0;
      rep_first  <= 1'b0;
      rep_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      if (state_nx != state || !lvl_inc) begin
        rep_active <= 1'b0;
        rep_cnt    <= '0;
      end else if (rep_start) begin
        rep_active <= 1'b1;
        rep_first  <= 1'b1;
        rep_cnt    <= '0;
      end else if (rep_fire) begin
        rep_first <= 1'b0;
        rep_cnt   <= '0;
      end else if (rep_active && rep_cnt != '1) begin
        rep_cnt <= rep_cnt + CNT_W'(1);
      end
      if (state_nx != state || state == RUN || activity) begin
        to_cnt <= '0;
      end else if (to_cnt != '1) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
    end
  end

  logic set_mode_w;
  assign set_mode_w   = (state != RUN);
  assign bus.set_mode = set_mode_w;
  assign bus.sel_hr   = sel_q;
  assign bus.load_o   = load_q;
  assign bus.inc_hr   = inc_hr_q;
  assign bus.inc_min  = inc_min_q;
  assign bus.commit_o = commit_q;
  assign bus.abort_o  = abort_q;
  assign bus.LED_hr   = led_on(set_mode_w, sel_q, FIELD_HR);
  assign bus.LED_min  = led_on(set_mode_w, sel_q, FIELD_MIN);

  logic unused_levels;
  assign unused_levels = lvl_mode ^ lvl_sel;

endmodule

// File: tb/tb_set_ctrl.sv
// tb/tb_set_ctrl.sv - directed and random checks of set_ctrl against a timing-rule model
module tb_set_ctrl;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int TO = 100;
  localparam logic [8:0] RESET_OUT = 9'b010000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_ctrl_if bus();

  set_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: state as int, repeat and timeout as absolute due-edge numbers,
  // debounce as "last D synchronized samples all differ from the level".
  int          ecount = 0;
  int          m_st;
  bit          m_sel;
  bit          m_rep_on;
  int          m_next_rep;
  int          m_last_act;
  bit          m_lvl [3];
  bit          m_prs [3];
  bit          m_arm [3];
  logic [63:0] m_hist [3];
  int          m_nsamp [3];
  logic [8:0]  m_out;

  int cnt_load = 0, cnt_inc_hr = 0, cnt_inc_min = 0, cnt_commit = 0, cnt_abort = 0;
  int last_load_cyc = 0, last_inc_cyc = 0, last_abort_cyc = 0;

  function automatic logic [8:0] dut_out();
    return {bus.set_mode, bus.sel_hr, bus.load_o, bus.inc_hr, bus.inc_min,
            bus.commit_o, bus.abort_o, bus.LED_hr, bus.LED_min};
  endfunction

  task automatic model_reset();
    m_st     = 0;
    m_sel    = 1'b1;
    m_rep_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_lvl[k]   = 1'b0;
      m_prs[k]   = 1'b0;
      m_arm[k]   = 1'b0;
      m_hist[k]  = '1;
      m_nsamp[k] = 0;
    end
    m_out = RESET_OUT;
  endtask

  task automatic model_edge(input bit rm, input bit rs, input bit ri);
    bit ld, ih, im, cm, ab, rep_due, flip, arm_prev, r, sync;
    ld = 0; ih = 0; im = 0; cm = 0; ab = 0;
    ecount++;
    rep_due = m_rep_on && m_lvl[2] && (ecount == m_next_rep);
    if (m_st == 0) begin
      if (m_prs[0]) begin
        m_st = 1; m_sel = 1'b1; ld = 1; m_last_act = ecount;
      end
    end else begin
      if (m_prs[0]) begin
        m_st = 0; cm = 1; m_rep_on = 0;
      end else if (m_prs[1]) begin
        m_st = (m_st == 1) ? 2 : 1; m_sel = (m_st == 1); m_last_act = ecount; m_rep_on = 0;
      end else if (m_prs[2] || rep_due) begin
        if (m_st == 1) ih = 1; else im = 1;
        m_last_act = ecount;
        if (m_prs[2]) begin
          m_rep_on = 1; m_next_rep = ecount + RD;
        end else begin
          m_next_rep = ecount + RR;
        end
      end else if (ecount == m_last_act + TO) begin
        m_st = 0; ab = 1; m_rep_on = 0;
      end
      if (!m_lvl[2]) m_rep_on = 0;
    end
    for (int k = 0; k < 3; k++) begin
      r = (k == 0) ? rm : (k == 1) ? rs : ri;
      m_hist[k] = {m_hist[k][62:0], r};
      m_nsamp[k]++;
      sync = m_hist[k][2];
      flip = (m_nsamp[k] >= D);
      for (int j = 0; j < D; j++) if (m_hist[k][2+j] == m_lvl[k]) flip = 0;
      arm_prev = m_arm[k];
      if (!m_lvl[k] && !sync) m_arm[k] = 1'b1;
      m_prs[k] = 1'b0;
      if (flip) begin
        m_lvl[k] = ~m_lvl[k];
        m_prs[k] = m_lvl[k] && arm_prev;
      end
    end
    m_out = {m_st != 0, m_sel, ld, ih, im, cm, ab, (m_st != 0) && m_sel, (m_st != 0) && !m_sel};
  endtask

  // Called at a negedge: drive keys, let one rising edge pass, then compare.
  task automatic step(input bit m, input bit s, input bit i);
    bus.key_mode = m;
    bus.key_sel  = s;
    bus.key_inc  = i;
    @(posedge clk);
    #1;
    model_edge(m, s, i);
    chk($sformatf("outputs@%0d", ecount), 32'(dut_out()), 32'(m_out));
    if (bus.load_o)   begin cnt_load++;    last_load_cyc  = ecount; end
    if (bus.inc_hr)   begin cnt_inc_hr++;  last_inc_cyc   = ecount; end
    if (bus.inc_min)  begin cnt_inc_min++; last_inc_cyc   = ecount; end
    if (bus.commit_o) cnt_commit++;
    if (bus.abort_o)  begin cnt_abort++;   last_abort_cyc = ecount; end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(0, 0, 0);
  endtask

  task automatic tap(input bit m, input bit s, input bit i);
    for (int c = 0; c < 10; c++) step(m, s, i);
    idle(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(dut_out()), 32'(RESET_OUT));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int t0, c0, c1, c2;
  int hold [3];
  bit lvl [3];

  initial begin
    bus.key_mode = 1'b0;
    bus.key_sel  = 1'b0;
    bus.key_inc  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("reset_state", 32'(dut_out()), 32'(RESET_OUT));
    idle(5);

    // 1: mode tap enters SET_HR with load at edge 7, second tap commits
    t0 = ecount;
    tap(1, 0, 0);
    chk("s1_load_edge", 32'(last_load_cyc - t0), 32'd7);
    chk("s1_set_mode", 32'(bus.set_mode), 32'd1);
    chk("s1_led_hr", 32'(bus.LED_hr), 32'd1);
    c0 = cnt_commit;
    tap(1, 0, 0);
    chk("s1_commit", 32'(cnt_commit - c0), 32'd1);
    chk("s1_run", 32'(bus.set_mode), 32'd0);

    // 2: bounce gives nothing, clean press gives one inc_hr
    tap(1, 0, 0);
    c0 = cnt_inc_hr;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
    idle(10);
    chk("s2_bounce", 32'(cnt_inc_hr - c0), 32'd0);
    tap(0, 0, 1);
    chk("s2_clean", 32'(cnt_inc_hr - c0), 32'd1);

    // 3: SET_MIN, inc held 60 cycles: strobes at t0, +20, +25 ... up to release
    tap(0, 1, 0);
    chk("s3_led_min", 32'(bus.LED_min), 32'd1);
    c0 = cnt_inc_min;
    for (int c = 0; c < 60; c++) step(0, 0, 1);
    idle(30);
    chk("s3_repeat_count", 32'(cnt_inc_min - c0), 32'd9);

    // 4: timeout after 100 idle cycles, then delayed by a press
    c0 = cnt_abort;
    c1 = cnt_commit;
    t0 = ecount;
    for (int c = 0; c < 10; c++) step(0, 1, 0);
    idle(110);
    chk("s4_abort_count", 32'(cnt_abort - c0), 32'd1);
    chk("s4_abort_delay", 32'(last_abort_cyc - (t0 + 7)), 32'd100);
    chk("s4_no_commit", 32'(cnt_commit - c1), 32'd0);
    chk("s4_run", 32'(bus.set_mode), 32'd0);
    for (int c = 0; c < 10; c++) step(1, 0, 0);
    idle(76);
    for (int c = 0; c < 10; c++) step(0, 0, 1);
    idle(120);
    chk("s4_abort_count2", 32'(cnt_abort - c0), 32'd2);
    chk("s4_abort_after_press", 32'(last_abort_cyc - last_inc_cyc), 32'd100);

    // 5: mode and sel together in SET_MIN -> commit only, sel_hr stays 0
    tap(1, 0, 0);
    tap(0, 1, 0);
    c0 = cnt_commit;
    tap(1, 1, 0);
    chk("s5_commit", 32'(cnt_commit - c0), 32'd1);
    chk("s5_run", 32'(bus.set_mode), 32'd0);
    chk("s5_sel_hr", 32'(bus.sel_hr), 32'd0);

    // 6: reset mid-edit with inc held, then no strobe until re-press
    tap(1, 0, 0);
    tap(0, 1, 0);
    for (int c = 0; c < 15; c++) step(0, 0, 1);
    c0 = cnt_inc_hr + cnt_inc_min;
    c1 = cnt_commit + cnt_abort + cnt_load;
    do_reset();
    for (int c = 0; c < 30; c++) step(0, 0, 1);
    idle(10);
    chk("s6_no_inc", 32'(cnt_inc_hr + cnt_inc_min - c0), 32'd0);
    chk("s6_no_other", 32'(cnt_commit + cnt_abort + cnt_load - c1), 32'd0);
    chk("s6_run", 32'(bus.set_mode), 32'd0);
    tap(1, 0, 0);
    c2 = cnt_inc_hr;
    tap(0, 0, 1);
    chk("s6_rearmed", 32'(cnt_inc_hr - c2), 32'd1);

    // random keys with bounce, long holds and the occasional reset
    for (int k = 0; k < 3; k++) begin
      hold[k] = 0;
      lvl[k]  = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          lvl[k]  = ~lvl[k];
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
          if (k == 0 && lvl[k]) hold[k] = $urandom_range(1, 12);
        end
        hold[k]--;
      end
      if ($urandom_range(0, 1999) == 0) do_reset();
      step(lvl[0], lvl[1], lvl[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
